regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-port controller for the 32x32 register file: arbitrates three writeback requesters (ALU, load/store unit, multiplier) onto the register file's single write port, and keeps a per-register busy scoreboard for the issue stage. Sits between the execution units and the register file's `wb_en`/`rd_index`/`wb_data` write port. Issue-stage hazard logic reads the scoreboard to stall instructions whose sources have writes pending.

## Interface
- `DATA_W`, 32, writeback data width
- `ADDR_W`, 5, register index width (32 registers; x0 hardwired zero)
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  3  per-requester writeback request; bit 0 = ALU, 1 = LSU, 2 = MUL
- `req_rd`  in  3*ADDR_W  destination index; requester i at bits [i*ADDR_W +: ADDR_W]
- `req_data`  in  3*DATA_W  writeback data; requester i at bits [i*DATA_W +: DATA_W]
- `req_ready`  out  3  one-hot grant; a handshake completes when `req_valid[i] && req_ready[i]`
- `wb_en`  out  1  register-file write enable (registered)
- `wb_rd`  out  ADDR_W  register-file write index (registered)
- `wb_data`  out  DATA_W  register-file write data (registered)
- `issue_en`  in  1  an instruction with a destination register issues this cycle
- `issue_rd`  in  ADDR_W  its destination index
- `rs1_index`, `rs2_index`  in  ADDR_W each  source indices to check
- `rs1_busy`, `rs2_busy`  out  1 each  combinational lookup of the scoreboard
- `busy`  out  32  full scoreboard vector (registered state)

## Operation
- Arbitration is round-robin over the valid requesters, with at most one grant per cycle. `rr_last` (2 bits) records the index of the last requester granted. The search order starts at `rr_last+1` and wraps 2->0.
- `req_ready` is combinational from `req_valid` and `rr_last`. It is all-zero when no request is valid, and it never depends on `wb_*`.
- `rr_last` updates to the granted index only on a completed handshake. If there is no request, it holds.
- Requesters hold `req_valid`, `req_rd` and `req_data` stable until ready. Dropping valid without a handshake is legal, and nothing is recorded for it.
- On a handshake, at the next edge: `wb_en <= (rd != 0)`, `wb_rd <= rd`, `wb_data <= data`. A request with rd = 0 is consumed without a write.
- With no handshake: `wb_en <= 0`, and `wb_rd`/`wb_data` hold their values.
- Scoreboard at each edge:
  - If `issue_en && issue_rd != 0`, set `busy[issue_rd]`.
  - If `wb_en`, clear `busy[wb_rd]`. The clear happens on the same edge at which the register file commits the write.
  - If set and clear target the same index on the same edge, set wins: a new producer has issued.
- `busy[0]` is constant 0.
- `rsN_busy = busy[rsN_index]`. It stays 1 during the cycle `wb_en` is high, because the register file's asynchronous read still returns the old value until the edge.
- A writeback to a register that is not busy is legal. It writes, and the scoreboard is unchanged.

## Timing
- Reset values (asynchronous, while `rst_n` = 0):
  - `wb_en` = 0, `wb_rd` = 0, `wb_data` = 0, `busy` = 0.
  - `rr_last` = 2, so requester 0 has first priority.
  - `req_ready` = 0 regardless of `req_valid`.
- Latency: from handshake in cycle N, `wb_en` is high in cycle N+1 and the register file is written at the end of N+1. The busy bit clears at that same edge, so a dependent read is clean in cycle N+2.
- Throughput: one writeback per cycle sustained. Each of k continuously-valid requesters is granted once every k cycles.
- Reset asserted mid-operation: any pending `wb_en` is squashed immediately (asynchronous). All busy bits clear and the round-robin restarts at requester 0. Requesters must re-present after reset.
- Reset release is synchronized externally. The block does not resynchronize `rst_n`.

## Test plan
- Reset: drive `rst_n` = 0 with all `req_valid` = 1. Required: `req_ready` = 0, `wb_en` = 0, `busy` = 0. After release, the first grant goes to requester 0.
- Single write: ALU valid with rd = 5, data = 0xDEADBEEF, after `issue_en` with `issue_rd` = 5 the cycle before. Required: `busy[5]` = 1. The next cycle has `wb_en` = 1, `wb_rd` = 5, `wb_data` = 0xDEADBEEF. After that edge `busy[5]` = 0, and `rs1_busy` for index 5 goes 1 -> 0.
- Round-robin: all three valid continuously for 6 cycles with distinct rd values 1, 2, 3. Required: grant order 0, 1, 2, 0, 1, 2, with one `wb_en` per cycle and no gaps.
- x0: MUL requests rd = 0, data = 0x1234, and `issue_en` targets rd = 0. Required: handshake completes, `wb_en` stays 0, `busy[0]` stays 0.
- Set/clear collision: `wb_en` is writing rd = 7 while `issue_en` sets rd = 7 in the same cycle. Required: `busy[7]` = 1 after the edge.
- Reset mid-flight: assert `rst_n` = 0 in the cycle `wb_en` = 1 with `busy` = 0x0000_00A0. Required: `wb_en` drops immediately and `busy` = 0. After release, requester 0 wins over a simultaneously valid requester 1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-port controller for the 32x32 register file: round-robin writeback
// arbitration across ALU/LSU/MUL plus the per-register busy scoreboard.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            req_valid,
    input  logic [3*ADDR_W-1:0]   req_rd,
    input  logic [3*DATA_W-1:0]   req_data,
    output logic [2:0]            req_ready,
    output logic                  wb_en,
    output logic [ADDR_W-1:0]     wb_rd,
    output logic [DATA_W-1:0]     wb_data,
    input  logic                  issue_en,
    input  logic [ADDR_W-1:0]     issue_rd,
    input  logic [ADDR_W-1:0]     rs1_index,
    input  logic [ADDR_W-1:0]     rs2_index,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic [(2**ADDR_W)-1:0] busy
);

    localparam int NREG = 2 ** ADDR_W;

    logic [1:0]        rr_last_r;
    logic [2:0]        grant_s;
    logic [1:0]        grant_idx_s;
    logic              hs_s;
    logic [ADDR_W-1:0] sel_rd_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              wb_en_r;
    logic [ADDR_W-1:0] wb_rd_r;
    logic [DATA_W-1:0] wb_data_r;
    logic [NREG-1:0]   busy_r;
    logic [NREG-1:0]   busy_next_s;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        grant_s = 3'b000;
        case (rr_last_r)
            2'd0: begin
                if (req_valid[1])      grant_s = 3'b010;
                else if (req_valid[2]) grant_s = 3'b100;
                else if (req_valid[0]) grant_s = 3'b001;
                else                   grant_s = 3'b000;
            end
            2'd1: begin
                if (req_valid[2])      grant_s = 3'b100;
                else if (req_valid[0]) grant_s = 3'b001;
                else if (req_valid[1]) grant_s = 3'b010;
                else                   grant_s = 3'b000;
            end
            default: begin
                if (req_valid[0])      grant_s = 3'b001;
                else if (req_valid[1]) grant_s = 3'b010;
                else if (req_valid[2]) grant_s = 3'b100;
                else                   grant_s = 3'b000;
            end
        endcase
    end

    // Grants are suppressed while reset is held so nothing handshakes in reset.
    assign req_ready = rst_n ? grant_s : 3'b000;
    assign hs_s      = |(req_valid & req_ready);

    // Encode the grant and select the winning requester's payload.
    always_comb begin
        grant_idx_s = 2'd0;
        sel_rd_s    = req_rd[0 +: ADDR_W];
        sel_data_s  = req_data[0 +: DATA_W];
        case (req_ready)
            3'b010: begin
                grant_idx_s = 2'd1;
                sel_rd_s    = req_rd[ADDR_W +: ADDR_W];
                sel_data_s  = req_data[DATA_W +: DATA_W];
            end
            3'b100: begin
                grant_idx_s = 2'd2;
                sel_rd_s    = req_rd[2*ADDR_W +: ADDR_W];
                sel_data_s  = req_data[2*DATA_W +: DATA_W];
            end
            default: begin
                grant_idx_s = 2'd0;
                sel_rd_s    = req_rd[0 +: ADDR_W];
                sel_data_s  = req_data[0 +: DATA_W];
            end
        endcase
    end

    // Last-granted pointer; reset value 2 gives requester 0 first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_r <= 2'd2;
        end else if (hs_s) begin
            rr_last_r <= grant_idx_s;
        end
    end

    // Writeback register stage; x0 requests are consumed without a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en_r   <= 1'b0;
            wb_rd_r   <= {ADDR_W{1'b0}};
            wb_data_r <= {DATA_W{1'b0}};
        end else if (hs_s) begin
            wb_en_r   <= (sel_rd_s != {ADDR_W{1'b0}});
            wb_rd_r   <= sel_rd_s;
            wb_data_r <= sel_data_s;
        end else begin
            wb_en_r   <= 1'b0;
        end
    end

    // Scoreboard update: clear on commit, then set on issue so a new producer wins.
    always_comb begin
        busy_next_s = busy_r;
        if (wb_en_r) begin
            busy_next_s[wb_rd_r] = 1'b0;
        end else begin
            busy_next_s = busy_r;
        end
        if (issue_en && (issue_rd != {ADDR_W{1'b0}})) begin
            busy_next_s[issue_rd] = 1'b1;
        end else begin
            busy_next_s[0] = 1'b0;
        end
        busy_next_s[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    assign wb_en    = wb_en_r;
    assign wb_rd    = wb_rd_r;
    assign wb_data  = wb_data_r;
    assign busy     = busy_r;
    assign rs1_busy = busy_r[rs1_index];
    assign rs2_busy = busy_r[rs2_index];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a round-robin/scoreboard model
// predicts grants and writebacks, which are queued and compared cycle by cycle.
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_valid = 3'b000;
    logic [14:0] req_rd = 15'd0;
    logic [95:0] req_data = 96'd0;
    logic [2:0]  req_ready;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        issue_en = 1'b0;
    logic [4:0]  issue_rd = 5'd0;
    logic [4:0]  rs1_index = 5'd0;
    logic [4:0]  rs2_index = 5'd0;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [31:0] busy;

    int          tests_run = 0;
    int          tests_failed = 0;
    wb_exp_t     exp_q[$];
    logic [31:0] busy_m;
    int          rr_m;
    logic [4:0]  last_rd;
    logic [31:0] last_data;
    logic [2:0]  obs_ready;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
        .req_ready(req_ready),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .rs1_index(rs1_index), .rs2_index(rs2_index),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_grant(input logic [2:0] v, input int last);
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (last + k) % 3;
            if (v[idx]) return 3'b001 << idx;
        end
        return 3'b000;
    endfunction

    task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] data);
        req_rd[i*5 +: 5]    = rd;
        req_data[i*32 +: 32] = data;
    endtask

    task automatic model_reset();
        busy_m    = 32'd0;
        rr_m      = 2;
        last_rd   = 5'd0;
        last_data = 32'd0;
        exp_q.delete();
        exp_q.push_back('{en: 1'b0, rd: 5'd0, data: 32'd0});
    endtask

    // One clock cycle with the currently driven inputs; called at posedge+1.
    task automatic run_cycle();
        wb_exp_t    e, n;
        logic [2:0] g;
        int         gi;
        logic       iss_en;
        logic [4:0] iss_rd;
        @(negedge clk);
        g = exp_grant(req_valid, rr_m);
        obs_ready = req_ready;
        check_eq("req_ready", req_ready, g);
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_underflow at %0t", $time);
            e = '{en: 1'b0, rd: last_rd, data: last_data};
        end else begin
            e = exp_q.pop_front();
        end
        check_eq("wb_en", wb_en, e.en);
        check_eq("wb_rd", wb_rd, e.rd);
        check_eq("wb_data", wb_data, e.data);
        check_eq("busy", busy, busy_m);
        check_eq("rs1_busy", rs1_busy, busy_m[rs1_index]);
        check_eq("rs2_busy", rs2_busy, busy_m[rs2_index]);
        gi = g[0] ? 0 : (g[1] ? 1 : 2);
        if (g != 3'b000) begin
            n.rd   = req_rd[gi*5 +: 5];
            n.data = req_data[gi*32 +: 32];
            n.en   = (n.rd != 5'd0);
        end else begin
            n = '{en: 1'b0, rd: last_rd, data: last_data};
        end
        last_rd   = n.rd;
        last_data = n.data;
        exp_q.push_back(n);
        iss_en = issue_en;
        iss_rd = issue_rd;
        @(posedge clk);
        #1;
        if (e.en) busy_m[e.rd] = 1'b0;
        if (iss_en && iss_rd != 5'd0) busy_m[iss_rd] = 1'b1;
        busy_m[0] = 1'b0;
        if (g != 3'b000) rr_m = gi;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with every requester asserting valid.
        req_valid = 3'b111;
        set_req(0, 5'd1, 32'hA0A0_0001);
        set_req(1, 5'd2, 32'hB0B0_0002);
        set_req(2, 5'd3, 32'hC0C0_0003);
        #12;
        check_eq("rst_ready", req_ready, 3'b000);
        check_eq("rst_wb_en", wb_en, 1'b0);
        check_eq("rst_busy", busy, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_cycle();
        check_eq("first_grant", obs_ready, 3'b001);
        req_valid = 3'b000;
        run_cycle();

        // Single write with a dependent source lookup on rs1.
        rs1_index = 5'd5;
        rs2_index = 5'd2;
        issue_en = 1'b1;
        issue_rd = 5'd5;
        run_cycle();
        issue_en = 1'b0;
        req_valid = 3'b001;
        set_req(0, 5'd5, 32'hDEADBEEF);
        run_cycle();
        check_eq("single_busy5", busy[5], 1'b1);
        req_valid = 3'b000;
        run_cycle();
        run_cycle();
        check_eq("single_busy5_clear", busy[5], 1'b0);

        // x0 from MUL: consumed, never written, never marked busy.
        req_valid = 3'b100;
        set_req(2, 5'd0, 32'h0000_1234);
        issue_en = 1'b1;
        issue_rd = 5'd0;
        run_cycle();
        check_eq("x0_grant", obs_ready, 3'b100);
        req_valid = 3'b000;
        issue_en = 1'b0;
        run_cycle();
        check_eq("x0_busy0", busy[0], 1'b0);

        // Round-robin with all three continuously valid.
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            set_req(0, 5'd1, 32'h1000_0000 + k);
            set_req(1, 5'd2, 32'h2000_0000 + k);
            set_req(2, 5'd3, 32'h3000_0000 + k);
            run_cycle();
            check_eq("rr_order", obs_ready, 3'b001 << (k % 3));
        end
        req_valid = 3'b000;
        run_cycle();

        // Set/clear collision on rd 7.
        req_valid = 3'b001;
        set_req(0, 5'd7, 32'h7777_0007);
        run_cycle();
        req_valid = 3'b000;
        issue_en = 1'b1;
        issue_rd = 5'd7;
        run_cycle();
        check_eq("collision_busy7", busy[7], 1'b1);

        // Reset mid-flight with busy = 0xA0 and a write in progress.
        issue_rd = 5'd5;
        run_cycle();
        issue_en = 1'b0;
        req_valid = 3'b001;
        set_req(0, 5'd5, 32'h5555_5555);
        run_cycle();
        req_valid = 3'b011;
        set_req(1, 5'd9, 32'h9999_9999);
        @(negedge clk);
        check_eq("mid_wb_en_before", wb_en, 1'b1);
        check_eq("mid_busy_before", busy, 32'h0000_00A0);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_wb_en_squash", wb_en, 1'b0);
        check_eq("mid_busy_clear", busy, 32'd0);
        check_eq("mid_ready_rst", req_ready, 3'b000);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_req(0, 5'd4, 32'h4444_4444);
        run_cycle();
        check_eq("post_rst_grant", obs_ready, 3'b001);
        req_valid = 3'b000;
        run_cycle();
        run_cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
